// File: rtl/out_ram_nbank_pkg.sv
// Shared types and sizing helpers for the N-bank output RAM switch.
// Defaults describe the standard 2-bank, 256-bit-beat, 32-bit-word build.
package out_ram_nbank_pkg;

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL
    } bank_state_t;

    // clog2 that never returns 0, so one-bank builds keep a 1-bit pointer
    function automatic int f_min1_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int N_BANKS_DEF        = 2;
    localparam int S_DATA_WIDTH_DEF   = 256;
    localparam int OUT_BITS_DEF       = 32;
    localparam int OUT_ADDR_WIDTH_DEF = 10;

    localparam int WORDS_PER_BEAT = S_DATA_WIDTH_DEF / OUT_BITS_DEF;
    localparam int BEAT_ADDR_W    = OUT_ADDR_WIDTH_DEF - $clog2(WORDS_PER_BEAT);
    localparam int DEPTH          = 1 << BEAT_ADDR_W;
    localparam int BANK_W         = f_min1_clog2(N_BANKS_DEF);

endpackage

// File: rtl/out_ram_bank.sv
// One bank: simple-dual-port RAM, DW x 2^AW, registered read port.
// Ports: i_we/i_waddr/i_wdata write side; i_re/i_raddr/o_rdata read side.
module out_ram_bank #(
    parameter int DW = 256,
    parameter int AW = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q;

    // RAM array itself carries no reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/out_ram_nbank.sv
// N-bank output RAM switch: fills banks round-robin from an AXI-stream,
// exposes the oldest full bank through a byte-addressed BRAM read port.
// Ports: s_* stream in; bram_* host read; t_done_fill/t_done_proc bank
// handshake; bank_beats, overflow_err status.
// Optional: define OUT_RAM_STALL_CNT_EN to add stall_cycles[31:0].
module out_ram_nbank
    import out_ram_nbank_pkg::*;
#(
    parameter int N_BANKS        = 2,
    parameter int S_DATA_WIDTH   = 256,
    parameter int OUT_BITS       = 32,
    parameter int OUT_ADDR_WIDTH = 10
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [S_DATA_WIDTH-1:0]   s_data,
    input  logic                      s_last,
    input  logic [OUT_ADDR_WIDTH+1:0] bram_addr_a,
    input  logic                      bram_en_a,
    output logic [OUT_BITS-1:0]       bram_rddata_a,
    output logic                      t_done_fill,
    input  logic                      t_done_proc,
    output logic [OUT_ADDR_WIDTH:0]   bank_beats,
    output logic                      overflow_err
`ifdef OUT_RAM_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int WPB    = S_DATA_WIDTH / OUT_BITS;
    localparam int LSH    = $clog2(WPB);
    localparam int LANE_W = f_min1_clog2(WPB);
    localparam int BA_W   = OUT_ADDR_WIDTH - LSH;
    localparam int BK_W   = f_min1_clog2(N_BANKS);
    localparam int CNT_W  = OUT_ADDR_WIDTH + 1;

    bank_state_t             r_state [N_BANKS];
    logic [CNT_W-1:0]        r_beats [N_BANKS];
    logic [BK_W-1:0]         r_wb;
    logic [BK_W-1:0]         r_rb;
    logic [BA_W-1:0]         r_wptr;
    logic                    r_ovf;
    logic [BK_W-1:0]         r_rsel;
    logic [LANE_W-1:0]       r_lane;

    logic [S_DATA_WIDTH-1:0] w_q [N_BANKS];
    logic [S_DATA_WIDTH-1:0] w_rd_beat;
    logic [OUT_ADDR_WIDTH-1:0] w_word;
    logic [BA_W-1:0]         w_rbeat;
    logic [LANE_W-1:0]       w_lane;
    logic                    w_acc;
    logic                    w_at_end;
    logic                    w_fill_done;
    logic                    w_rel;
    logic [BK_W-1:0]         w_wb_nxt;
    logic [BK_W-1:0]         w_rb_nxt;
    logic                    w_unused;

    assign s_ready     = (r_state[r_wb] != B_FULL);
    assign t_done_fill = (r_state[r_rb] == B_FULL);
    assign bank_beats  = r_beats[r_rb];
    assign overflow_err = r_ovf;

    assign w_acc       = s_valid && s_ready;
    assign w_at_end    = (r_wptr == BA_W'(DEPTH_OF(BA_W) - 1));
    assign w_fill_done = w_acc && (s_last || w_at_end);
    assign w_rel       = t_done_proc && t_done_fill;

    // Explicit compare-and-wrap so non-power-of-two bank counts work
    assign w_wb_nxt = (r_wb == BK_W'(N_BANKS - 1)) ? '0 : r_wb + 1'b1;
    assign w_rb_nxt = (r_rb == BK_W'(N_BANKS - 1)) ? '0 : r_rb + 1'b1;

    function automatic int DEPTH_OF(input int aw);
        return 1 << aw;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_BANKS; i++) begin
                r_state[i] <= B_EMPTY;
                r_beats[i] <= '0;
            end
            r_wb   <= '0;
            r_rb   <= '0;
            r_wptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            // Fill and release never target the same bank: one needs it
            // FULL, the other needs it not FULL.
            if (w_acc) begin
                if (w_fill_done) begin
                    r_state[r_wb] <= B_FULL;
                    r_beats[r_wb] <= CNT_W'(r_wptr) + 1'b1;
                    r_wptr        <= '0;
                    r_wb          <= w_wb_nxt;
                    if (!s_last) begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_state[r_wb] <= B_FILLING;
                    r_wptr        <= r_wptr + 1'b1;
                end
            end
            if (w_rel) begin
                r_state[r_rb] <= B_EMPTY;
                r_rb          <= w_rb_nxt;
            end
        end
    end

    assign w_word  = bram_addr_a[OUT_ADDR_WIDTH+1:2];
    assign w_rbeat = w_word[OUT_ADDR_WIDTH-1:LSH];

    if (LSH == 0) begin : g_one_lane
        assign w_lane = '0;
    end else begin : g_lanes
        assign w_lane = w_word[LSH-1:0];
    end

    assign w_unused = &{1'b0, bram_addr_a[1:0]};

    // Bank select and lane are captured with the RAM read so the output
    // holds while bram_en_a is low
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rsel <= '0;
            r_lane <= '0;
        end else if (bram_en_a) begin
            r_rsel <= r_rb;
            r_lane <= w_lane;
        end
    end

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        out_ram_bank #(
            .DW (S_DATA_WIDTH),
            .AW (BA_W)
        ) u_bank (
            .i_clk   (aclk),
            .i_rst_n (aresetn),
            .i_we    (w_acc && (r_wb == BK_W'(g))),
            .i_waddr (r_wptr),
            .i_wdata (s_data),
            .i_re    (bram_en_a),
            .i_raddr (w_rbeat),
            .o_rdata (w_q[g])
        );
    end

    assign w_rd_beat     = w_q[r_rsel];
    assign bram_rddata_a = w_rd_beat[r_lane*OUT_BITS +: OUT_BITS];

`ifdef OUT_RAM_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stall <= '0;
        end else if (s_valid && !s_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule
